// File: rtl/initmem_loader.sv
// initmem_loader: boot-time copy engine. Reads WORD_COUNT words from a source
// Avalon-MM port, writes them to a destination RAM, optionally reads each one
// back and compares, then flags done or the first mismatching address.
module initmem_loader #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SRC_ADDR_WIDTH = 17,
   parameter int unsigned DST_ADDR_WIDTH = 12,
   parameter int unsigned WORD_COUNT     = 1024,
   parameter int unsigned SRC_BASE       = 0,
   parameter int unsigned DST_BASE       = 0,
   parameter int unsigned VERIFY         = 1,
   parameter int unsigned AUTOSTART      = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic [SRC_ADDR_WIDTH-1:0] avm_src_address,
   output logic                      avm_src_read,
   input  logic                      avm_src_waitrequest,
   input  logic                      avm_src_readdatavalid,
   input  logic [DATA_WIDTH-1:0]     avm_src_readdata,
   output logic [DST_ADDR_WIDTH-1:0] avm_dst_address,
   output logic                      avm_dst_write,
   output logic                      avm_dst_read,
   output logic [DATA_WIDTH-1:0]     avm_dst_writedata,
   input  logic                      avm_dst_waitrequest,
   input  logic                      avm_dst_readdatavalid,
   input  logic [DATA_WIDTH-1:0]     avm_dst_readdata,
   input  logic                      coe_start,
   output logic                      coe_initdone,
   output logic                      coe_initerror,
   output logic [DST_ADDR_WIDTH-1:0] coe_erraddr
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRC_RD,
      ST_SRC_WAIT,
      ST_DST_WR,
      ST_DST_RD,
      ST_DST_WAIT,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [SRC_ADDR_WIDTH-1:0] SRC_BASE_A = SRC_ADDR_WIDTH'(SRC_BASE);
   localparam logic [DST_ADDR_WIDTH-1:0] DST_BASE_A = DST_ADDR_WIDTH'(DST_BASE);
   localparam logic [DST_ADDR_WIDTH-1:0] LAST_IDX   = DST_ADDR_WIDTH'(WORD_COUNT - 1);

   state_t                    state_q, state_d;
   logic [DST_ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
   logic                      src_read_q, src_read_d;
   logic [DST_ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
   logic                      dst_write_q, dst_write_d;
   logic                      dst_read_q, dst_read_d;
   // Holds the word fetched from the source; doubles as the verify reference.
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      initdone_q, initdone_d;
   logic                      initerror_q, initerror_d;
   logic [DST_ADDR_WIDTH-1:0] erraddr_q, erraddr_d;
   logic                      start_prev_q;

   logic                      start_rise;
   logic                      latch_src;
   logic                      chk_rd;
   logic                      advance;
   logic                      launch;
   logic                      issue_rd;
   logic [DST_ADDR_WIDTH-1:0] rd_idx;

   // Next-state and next-output computation for the copy/verify sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      src_addr_d  = src_addr_q;
      src_read_d  = src_read_q;
      dst_addr_d  = dst_addr_q;
      dst_write_d = dst_write_q;
      dst_read_d  = dst_read_q;
      wdata_d     = wdata_q;
      initdone_d  = initdone_q;
      initerror_d = initerror_q;
      erraddr_d   = erraddr_q;
      start_rise  = coe_start & ~start_prev_q;
      latch_src   = 1'b0;
      chk_rd      = 1'b0;
      advance     = 1'b0;
      launch      = 1'b0;
      issue_rd    = 1'b0;
      rd_idx      = idx_q;

      case (state_q)
         ST_IDLE: begin
            if ((AUTOSTART != 0) || start_rise) launch = 1'b1;
         end
         ST_SRC_RD: begin
            if (!avm_src_waitrequest) begin
               src_read_d = 1'b0;
               if (avm_src_readdatavalid) latch_src = 1'b1;
               else                       state_d   = ST_SRC_WAIT;
            end
         end
         ST_SRC_WAIT: begin
            if (avm_src_readdatavalid) latch_src = 1'b1;
         end
         ST_DST_WR: begin
            if (!avm_dst_waitrequest) begin
               dst_write_d = 1'b0;
               if (VERIFY != 0) begin
                  state_d    = ST_DST_RD;
                  dst_read_d = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_DST_RD: begin
            if (!avm_dst_waitrequest) begin
               dst_read_d = 1'b0;
               if (avm_dst_readdatavalid) chk_rd  = 1'b1;
               else                       state_d = ST_DST_WAIT;
            end
         end
         ST_DST_WAIT: begin
            if (avm_dst_readdatavalid) chk_rd = 1'b1;
         end
         ST_DONE, ST_ERROR: begin
            if (start_rise) launch = 1'b1;
         end
         default: ;
      endcase

      // Source word arrived: capture it and present the destination write.
      if (latch_src) begin
         wdata_d     = avm_src_readdata;
         dst_addr_d  = DST_BASE_A + idx_q;
         dst_write_d = 1'b1;
         state_d     = ST_DST_WR;
      end

      if (chk_rd) begin
         if (avm_dst_readdata != wdata_q) begin
            state_d     = ST_ERROR;
            initerror_d = 1'b1;
            erraddr_d   = dst_addr_q;
         end else begin
            advance = 1'b1;
         end
      end

      if (advance) begin
         if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            initdone_d = 1'b1;
         end else begin
            issue_rd = 1'b1;
            rd_idx   = idx_q + DST_ADDR_WIDTH'(1);
         end
      end

      // New run: erraddr is deliberately left holding the last failure.
      if (launch) begin
         issue_rd    = 1'b1;
         rd_idx      = '0;
         initdone_d  = 1'b0;
         initerror_d = 1'b0;
      end

      if (issue_rd) begin
         idx_d      = rd_idx;
         state_d    = ST_SRC_RD;
         src_read_d = 1'b1;
         src_addr_d = SRC_BASE_A + SRC_ADDR_WIDTH'(rd_idx);
      end
   end

   // State and registered outputs; start edge detector resets high so a level
   // held through reset is not seen as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         src_addr_q   <= '0;
         src_read_q   <= 1'b0;
         dst_addr_q   <= '0;
         dst_write_q  <= 1'b0;
         dst_read_q   <= 1'b0;
         wdata_q      <= '0;
         initdone_q   <= 1'b0;
         initerror_q  <= 1'b0;
         erraddr_q    <= '0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         src_addr_q   <= src_addr_d;
         src_read_q   <= src_read_d;
         dst_addr_q   <= dst_addr_d;
         dst_write_q  <= dst_write_d;
         dst_read_q   <= dst_read_d;
         wdata_q      <= wdata_d;
         initdone_q   <= initdone_d;
         initerror_q  <= initerror_d;
         erraddr_q    <= erraddr_d;
         start_prev_q <= coe_start;
      end
   end

   assign avm_src_address   = src_addr_q;
   assign avm_src_read      = src_read_q;
   assign avm_dst_address   = dst_addr_q;
   assign avm_dst_write     = dst_write_q;
   assign avm_dst_read      = dst_read_q;
   assign avm_dst_writedata = wdata_q;
   assign coe_initdone      = initdone_q;
   assign coe_initerror     = initerror_q;
   assign coe_erraddr       = erraddr_q;

endmodule

// File: doc/initmem_loader.md
# initmem_loader

Boot-time memory initialiser: copies `WORD_COUNT` words from a source Avalon-MM read port (UFM/flash data region) into a destination on-chip RAM through an Avalon-MM master, optionally reads back and verifies each word, then raises `coe_initdone`. It sits beside the CPU subsystem in the board top level. It replaces the fixed single-image init path with a parametrised engine that supports re-triggering, verification and error reporting.

## Interface
- `DATA_WIDTH`, 32: word width on both ports.
- `SRC_ADDR_WIDTH`, 17: source word-address width.
- `DST_ADDR_WIDTH`, 12: destination word-address width.
- `WORD_COUNT`, 1024: words per run; legal range 1 to 2^DST_ADDR_WIDTH.
- `SRC_BASE`, 0: first source word address.
- `DST_BASE`, 0: first destination word address.
- `VERIFY`, 1: 1 = read back and compare each word after it is written.
- `AUTOSTART`, 1: 1 = start a run automatically after reset.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `avm_src_address`  out  SRC_ADDR_WIDTH  source word address.
- `avm_src_read`  out  1  source read request.
- `avm_src_waitrequest`  in  1  source stall.
- `avm_src_readdatavalid`  in  1  source data valid.
- `avm_src_readdata`  in  DATA_WIDTH  source data.
- `avm_dst_address`  out  DST_ADDR_WIDTH  destination word address.
- `avm_dst_write`  out  1  destination write request.
- `avm_dst_read`  out  1  destination read request (verify pass).
- `avm_dst_writedata`  out  DATA_WIDTH  data to write.
- `avm_dst_waitrequest`  in  1  destination stall.
- `avm_dst_readdatavalid`  in  1  destination data valid.
- `avm_dst_readdata`  in  DATA_WIDTH  readback data.
- `coe_start`  in  1  level input; a rising edge starts a run.
- `coe_initdone`  out  1  high while the run has completed with no error.
- `coe_initerror`  out  1  high after a verify mismatch.
- `coe_erraddr`  out  DST_ADDR_WIDTH  destination address of the first mismatch.

## Operation
- States: IDLE, SRC_RD, SRC_WAIT, DST_WR, DST_RD, DST_WAIT, DONE, ERROR.
- Word index `idx` runs from 0 to WORD_COUNT-1.
  - Source address = (SRC_BASE+idx) mod 2^SRC_ADDR_WIDTH.
  - Destination address = (DST_BASE+idx) mod 2^DST_ADDR_WIDTH.
- IDLE → SRC_RD:
  - If AUTOSTART=1: on the first clock edge after reset releases.
  - Otherwise: on a `coe_start` rising edge.
  - On entry, `idx` clears to 0, `coe_initdone` and `coe_initerror` clear, and `coe_erraddr` is held.
- SRC_RD:
  - `avm_src_read` is held high until it is sampled with `avm_src_waitrequest`=0.
  - If `avm_src_readdatavalid` is also high in that cycle (zero latency), data latches and the state goes to DST_WR.
  - Otherwise the state goes to SRC_WAIT.
- SRC_WAIT: latch `avm_src_readdata` on `avm_src_readdatavalid`, then go to DST_WR. At most one read is outstanding.
- DST_WR: `avm_dst_write` is held high with stable address and data until `avm_dst_waitrequest`=0. Next state is DST_RD if VERIFY=1, else the advance step.
- DST_RD / DST_WAIT: same handshake as SRC_RD / SRC_WAIT on the destination port. The readback is compared against the latched data.
  - Mismatch: go to ERROR and capture the destination address into `coe_erraddr`.
  - Match: advance.
- Advance:
  - If idx = WORD_COUNT-1, go to DONE.
  - Otherwise idx+1, then SRC_RD.
- DONE: `coe_initdone`=1. ERROR: `coe_initerror`=1 and the run stops with no further bus cycles.
- From DONE or ERROR, a `coe_start` rising edge starts a new run. `coe_start` edges are ignored in every other state.
- The `coe_start` edge detector is a registered previous value that resets to 1. A level held high through reset therefore does not trigger a run.
- `avm_src_read`, `avm_dst_write` and `avm_dst_read` are never high at the same time.

## Timing
- All outputs are registered.
- Reset values: all request strobes 0, addresses 0, writedata 0, `coe_initdone` 0, `coe_initerror` 0, `coe_erraddr` 0, state IDLE.
- Reset asserted mid-run aborts immediately; in-flight bus cycles are dropped. After release, AUTOSTART=1 reruns from idx 0.
- With zero waitrequest and readdatavalid one cycle after acceptance, per-word cost is:
  - VERIFY=0: 3 cycles (SRC_RD, SRC_WAIT, DST_WR).
  - VERIFY=1: 5 cycles.
- `coe_initdone` rises the cycle after the final write is accepted (VERIFY=0) or the final readback is accepted (VERIFY=1).
- `coe_initerror` and `coe_erraddr` update in the same cycle that the state becomes ERROR.
- Any amount of waitrequest stall and any readdatavalid latency must be tolerated. Addresses and data must not change while a request is stalled.

## Test plan
- AUTOSTART=1, VERIFY=0, WORD_COUNT=4, source returns 0x11,0x22,0x33,0x44 at latency 1 → writes to dst 0..3 with those values; `coe_initdone` high at cycle 13 after reset release; no further bus activity.
- VERIFY=1, random waitrequest (50%) and readdatavalid latency 0..3 on both ports, WORD_COUNT=16 → all 16 words written and read back exactly once each; `coe_initdone`=1, `coe_initerror`=0.
- VERIFY=1, destination model corrupts the word at address 5 → ERROR; `coe_erraddr`=5, `coe_initerror`=1, `coe_initdone`=0, no access to address 6.
- SRC_BASE=0x1FFFE, SRC_ADDR_WIDTH=17, WORD_COUNT=4 → source addresses 0x1FFFE, 0x1FFFF, 0x0, 0x1.
- AUTOSTART=0, `coe_start` held high through reset → no run. `coe_start` low then high → run starts. A second `coe_start` pulse mid-run is ignored. A pulse after DONE reruns, dropping `coe_initdone` at the start.
- Assert `reset` during DST_WR of word 2 → all outputs return to reset values asynchronously; after release the run restarts at idx 0.
